rr_arb_mux_4_1: RTL
===================

// Module: rr_arb_mux_4_1
//
// PURPOSE
//   Upstream arbitration stage for the 4:1 data mux. Four producers each
//   offer a WIDTH-bit word with valid/ready handshake. Block picks one per
//   cycle by round-robin and registers the word and its 2-bit select index.
//   The registered output feeds one downstream consumer through a valid/ready
//   handshake. out_sel equals the mux select code for the channel that won.
//
// PARAMETERS
//   WIDTH   4   data width per channel and of out_data
//
// PORTS
//   clk        in   1        clock, all state on rising edge
//   rst_n      in   1        reset, asynchronous, active-low
//   in_valid   in   4        per-channel valid, bit i = channel i
//   in_ready   out  4        per-channel ready, at most one bit set (one-hot or zero)
//   d0..d3     in   WIDTH    channel data 0..3
//   out_valid  out  1        output word valid (registered)
//   out_ready  in   1        downstream accepts output word
//   out_data   out  WIDTH    registered winning word
//   out_sel    out  2        registered index of winning channel
//
// BEHAVIOUR
//   - Reset (rst_n=0, takes effect immediately, no clock needed):
//     out_valid=0, out_data=0, out_sel=0, round-robin pointer ptr=0.
//     An in-flight output word is discarded.
//   - load = !out_valid | out_ready. The output register may take a new word
//     only when load=1.
//   - Grant (combinational): when load=1, scan channels in order
//     ptr, ptr+1, ptr+2, ptr+3 (mod 4). The first channel with in_valid set is
//     the grant g. Drive in_ready[g]=1 and all other bits 0.
//     When load=0 or in_valid=0000, in_ready=0000.
//   - Handshake rules:
//     - A transfer on channel i occurs when in_valid[i] & in_ready[i].
//     - in_ready may depend on in_valid.
//     - No output valid depends on a ready input. out_valid is purely registered.
//   - On a clock edge with a transfer on channel g:
//     out_valid<=1, out_data<=d[g], out_sel<=g, ptr<=(g+1) mod 4.
//     When g=3, ptr wraps to 0.
//   - On a clock edge with load=1 and no transfer:
//     out_valid<=0. out_data, out_sel and ptr hold.
//   - On a clock edge with load=0 (out_valid & !out_ready):
//     all registers hold. Output stays stable under backpressure.
//   - Simultaneous events: when out_ready=1 and a new grant occur in the same
//     cycle, the old word leaves and the new word loads on the same edge.
//     Throughput is 1 word per cycle.
//   - Latency: input transfer at edge N gives out_valid=1 with that word
//     after edge N.
//   - ptr changes only on a transfer. Idle cycles do not rotate priority.
//   - Starvation-free: a channel that holds valid is granted within
//     4 transfers.
//
// TESTING
//   1. Assert rst_n=0 mid-cycle with out_valid=1
//      -> out_valid=0, out_sel=0 immediately, before any clock edge.
//      After release, ptr=0.
//   2. All in_valid=1111, d0..d3=1,2,3,4, out_ready=1 held
//      -> out_sel=0,1,2,3,0,... and out_data=1,2,3,4,1,...
//      One word per cycle, in_ready one-hot rotating.
//   3. Only ch2 valid, d2=5, for 3 cycles
//      -> three words, out_sel=2, out_data=5, ptr=3.
//      Then in_valid=0110 -> ch1 granted first (scan order 3,0,1,2).
//   4. out_valid=1 (sel=1, data=9), out_ready=0 for 3 cycles, in_valid=1111
//      -> out_data=9, out_sel=1 stable and in_ready=0000 throughout.
//      Raise out_ready -> word consumed and next grant is ch2 on that edge.
//   5. Grant ch3 (in_valid=1000, ptr=0), then in_valid=1001
//      -> ch0 granted next, because ptr wrapped 3->0.
//   6. in_valid=0000 for 2 cycles with out_ready=1
//      -> out_valid falls to 0, ptr unchanged, in_ready=0000.

Source files
------------

// File: rtl/rr_arb_mux_4_1_if.sv
// ---------------------------------------------------------------------------
// rr_arb_mux_4_1_if
//
// Purpose:
//   Bundles the four producer channels and the single consumer channel of
//   the round-robin arbitration stage into one interface.
//
// Signals:
//   in_valid  [3:0]        per-channel valid, bit i = channel i
//   in_ready  [3:0]        per-channel ready, one-hot or zero
//   d0..d3    [WIDTH-1:0]  channel data words
//   out_valid              registered output word valid
//   out_ready              downstream accepts the output word
//   out_data  [WIDTH-1:0]  registered winning word
//   out_sel   [1:0]        registered index of the winning channel
//   dbg_ptr   [1:0]        current round-robin pointer (observability only)
//
// Modports:
//   master  the producer/consumer environment around the arbiter
//   slave   the arbiter itself
// ---------------------------------------------------------------------------
interface rr_arb_mux_4_1_if #(
    parameter int WIDTH = 4
);
    logic [3:0]       in_valid;
    logic [3:0]       in_ready;
    logic [WIDTH-1:0] d0;
    logic [WIDTH-1:0] d1;
    logic [WIDTH-1:0] d2;
    logic [WIDTH-1:0] d3;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_sel;
    logic [1:0]       dbg_ptr;

    modport master (
        output in_valid,
        input  in_ready,
        output d0,
        output d1,
        output d2,
        output d3,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_sel,
        input  dbg_ptr
    );

    modport slave (
        input  in_valid,
        output in_ready,
        input  d0,
        input  d1,
        input  d2,
        input  d3,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_sel,
        output dbg_ptr
    );
endinterface

// File: rtl/rr_arb_mux_4_1.sv
// ---------------------------------------------------------------------------
// rr_arb_mux_4_1
//
// Purpose:
//   Upstream arbitration stage for a 4:1 data mux. Four producers offer a
//   word each with a valid/ready handshake; one is picked per cycle by
//   round-robin and its word plus 2-bit channel index are registered and
//   presented to a single downstream consumer.
//
// Ports:
//   clk    in   clock, all state changes on the rising edge
//   rst_n  in   asynchronous active-low reset
//   bus    slave modport of rr_arb_mux_4_1_if (channels, output, dbg_ptr)
//
// Handshake semantics (both sides):
//   A word moves on a channel on a rising edge where valid and ready are
//   both high. valid never depends on ready; ready may depend on valid.
//   The output register is fully registered (out_valid/out_data/out_sel),
//   and holds stable while out_valid=1 and out_ready=0.
// ---------------------------------------------------------------------------
module rr_arb_mux_4_1 #(
    parameter int WIDTH = 4
) (
    input logic            clk,
    input logic            rst_n,
    rr_arb_mux_4_1_if.slave bus
);

    // Registered state
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic [1:0]       out_sel_q;
    logic [1:0]       ptr_q;

    // Grant path
    logic             load;
    logic             found;
    logic [1:0]       grant;
    logic [1:0]       scan_idx;
    logic             transfer;
    logic [3:0]       ready_vec;
    logic [WIDTH-1:0] grant_data;

    // The output slot is free when empty or when its word leaves this cycle,
    // which is what gives back-to-back throughput of one word per cycle.
    assign load = !out_valid_q || bus.out_ready;

    // Scan channels starting at the pointer; the first valid one wins.
    // The 2-bit index naturally wraps 3 -> 0.
    always_comb begin
        found    = 1'b0;
        grant    = ptr_q;
        scan_idx = ptr_q;
        for (int k = 0; k < 4; k++) begin
            scan_idx = ptr_q + 2'(k);
            if (!found && bus.in_valid[scan_idx]) begin
                found = 1'b1;
                grant = scan_idx;
            end
        end
    end

    assign transfer  = load && found;
    assign ready_vec = transfer ? (4'b0001 << grant) : 4'b0000;

    always_comb begin
        grant_data = bus.d0;
        case (grant)
            2'd0:    grant_data = bus.d0;
            2'd1:    grant_data = bus.d1;
            2'd2:    grant_data = bus.d2;
            default: grant_data = bus.d3;
        endcase
    end

    // Pointer moves past the winner only on a transfer, so idle cycles do
    // not rotate priority. Without load everything holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= 2'd0;
            ptr_q       <= 2'd0;
        end else if (transfer) begin
            out_valid_q <= 1'b1;
            out_data_q  <= grant_data;
            out_sel_q   <= grant;
            ptr_q       <= grant + 2'd1;
        end else if (load) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = ready_vec;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;
    assign bus.dbg_ptr   = ptr_q;

    // At most one producer is ever told it may transfer.
    a_ready_onehot0 : assert property (
        @(posedge clk) disable iff (!rst_n) $onehot0(bus.in_ready)
    );

    // A presented word is held unchanged under backpressure.
    a_hold_stable : assert property (
        @(posedge clk) disable iff (!rst_n)
        (bus.out_valid && !bus.out_ready)
            |=> (bus.out_valid && $stable(bus.out_data) && $stable(bus.out_sel))
    );

endmodule
